// File: rtl/hs_counter_bank.sv
//==============================================================================
// Module      : hs_counter_bank
// Description : Bank of independent 4-phase handshake counters with
//               synchronised requests, up/down, wrap/saturate, sticky overflow.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hs_counter_bank #(
    parameter int WIDTH       = 4,
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      arst_i,
    input  logic                      clr_i,
    input  logic                      dir_i,
    input  logic                      sat_i,
    input  logic [CHANNELS-1:0]       req_i,
    output logic [CHANNELS-1:0]       ack_o,
    output logic [CHANNELS*WIDTH-1:0] dout_o,
    output logic [CHANNELS-1:0]       ovf_o
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_ack  = 1'b1;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   w_req_s;
        logic [0:0]             r_state;
        logic [0:0]             w_state_nxt;
        logic                   w_fire;
        logic [WIDTH-1:0]       r_count;
        logic [WIDTH-1:0]       w_count_nxt;
        logic                   r_ovf;
        logic                   w_ovf_nxt;

        always_ff @(posedge clk or posedge arst_i) begin
            if (arst_i) begin
                r_sync <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], req_i[k]};
            end
        end

        assign w_req_s = r_sync[SYNC_STAGES-1];

        always_ff @(posedge clk or posedge arst_i) begin
            if (arst_i) begin
                r_state <= c_st_idle;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_fire      = 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_req_s) begin
                        w_state_nxt = c_st_ack;
                        w_fire      = 1'b1;
                    end
                end
                default: begin
                    if (!w_req_s) begin
                        w_state_nxt = c_st_idle;
                    end
                end
            endcase
        end

        // Direction and mode only matter on the single IDLE->ACK edge.
        always_comb begin
            w_count_nxt = r_count;
            w_ovf_nxt   = r_ovf;
            if (w_fire) begin
                if (dir_i) begin
                    if (r_count == {WIDTH{1'b1}}) begin
                        w_count_nxt = sat_i ? r_count : '0;
                        w_ovf_nxt   = 1'b1;
                    end else begin
                        w_count_nxt = r_count + WIDTH'(1);
                    end
                end else begin
                    if (r_count == '0) begin
                        w_count_nxt = sat_i ? r_count : {WIDTH{1'b1}};
                        w_ovf_nxt   = 1'b1;
                    end else begin
                        w_count_nxt = r_count - WIDTH'(1);
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge arst_i) begin
            if (arst_i) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (clr_i) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else begin
                r_count <= w_count_nxt;
                r_ovf   <= w_ovf_nxt;
            end
        end

        assign ack_o[k]                   = r_state[0];
        assign ovf_o[k]                   = r_ovf;
        assign dout_o[k*WIDTH +: WIDTH]   = r_count;
    end

endmodule

`default_nettype wire

// File: tb/tb_hs_counter_bank.sv
//==============================================================================
// Module      : tb_hs_counter_bank
// Description : Directed self-checking bench for hs_counter_bank (4-bit, 2 ch).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_hs_counter_bank;

    logic       clk = 1'b0;
    logic       arst_i = 1'b1;
    logic       clr_i = 1'b0;
    logic       dir_i = 1'b1;
    logic       sat_i = 1'b0;
    logic [1:0] req_i = 2'b00;
    logic [1:0] ack_o;
    logic [7:0] dout_o;
    logic [1:0] ovf_o;

    int n_tests = 0;
    int n_fail  = 0;

    hs_counter_bank #(.WIDTH(4), .CHANNELS(2), .SYNC_STAGES(2)) u_dut (
        .clk    (clk),
        .arst_i (arst_i),
        .clr_i  (clr_i),
        .dir_i  (dir_i),
        .sat_i  (sat_i),
        .req_i  (req_i),
        .ack_o  (ack_o),
        .dout_o (dout_o),
        .ovf_o  (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic handshake(input logic [1:0] mask);
        req_i = req_i | mask;
        tick(3);
        req_i = req_i & ~mask;
        tick(3);
    endtask

    initial begin
        tick(2);
        check("reset_ack", ack_o, 2'b00);
        check("reset_dout", dout_o, 8'h00);
        check("reset_ovf", ovf_o, 2'b00);
        arst_i = 1'b0;
        tick(1);

        // Single up handshake on ch0
        dir_i = 1'b1; sat_i = 1'b0;
        req_i = 2'b01;
        tick(2);
        check("ack0_edge2_low", ack_o[0], 1'b0);
        tick(1);
        check("ack0_edge3_high", ack_o[0], 1'b1);
        check("cnt0_first", dout_o[3:0], 4'd1);
        req_i = 2'b00;
        tick(2);
        check("ack0_fall_edge2", ack_o[0], 1'b1);
        tick(1);
        check("ack0_fall_edge3", ack_o[0], 1'b0);
        check("cnt0_hold", dout_o[3:0], 4'd1);

        // 16 up handshakes from 0, wrap mode
        clr_i = 1'b1; tick(1); clr_i = 1'b0;
        check("clr_dout", dout_o, 8'h00);
        for (int i = 0; i < 15; i++) handshake(2'b01);
        check("cnt0_15", dout_o[3:0], 4'd15);
        check("ovf0_pre", ovf_o[0], 1'b0);
        handshake(2'b01);
        check("cnt0_wrap", dout_o[3:0], 4'd0);
        check("ovf0_wrap", ovf_o[0], 1'b1);
        check("cnt1_idle", dout_o[7:4], 4'd0);
        check("ovf1_idle", ovf_o[1], 1'b0);

        // Saturating down at 0 on ch1, then one up
        sat_i = 1'b1; dir_i = 1'b0;
        handshake(2'b10);
        check("cnt1_sat0", dout_o[7:4], 4'd0);
        check("ovf1_sat0", ovf_o[1], 1'b1);
        dir_i = 1'b1;
        handshake(2'b10);
        check("cnt1_up", dout_o[7:4], 4'd1);
        check("ovf1_sticky", ovf_o[1], 1'b1);

        // Clear coincident with an update edge on ch0 at count 5
        sat_i = 1'b0;
        for (int i = 0; i < 5; i++) handshake(2'b01);
        check("cnt0_5", dout_o[3:0], 4'd5);
        req_i = 2'b01;
        tick(2);
        clr_i = 1'b1;
        tick(1);
        clr_i = 1'b0;
        check("clr_win_cnt", dout_o[3:0], 4'd0);
        check("clr_win_ovf", ovf_o[0], 1'b0);
        check("clr_win_ack", ack_o[0], 1'b1);
        req_i = 2'b00;
        tick(3);
        check("clr_win_ack_fall", ack_o[0], 1'b0);
        check("clr_win_hold", dout_o[3:0], 4'd0);

        // Simultaneous requests from 3 and 7
        for (int i = 0; i < 3; i++) handshake(2'b01);
        for (int i = 0; i < 7; i++) handshake(2'b10);
        check("pre_both", dout_o, 8'h73);
        req_i = 2'b11;
        tick(2);
        check("both_ack_low", ack_o, 2'b00);
        tick(1);
        check("both_ack_high", ack_o, 2'b11);
        check("both_cnt", dout_o, 8'h84);
        req_i = 2'b00;
        tick(3);

        // Down wrap from 0 on both, then saturate up at 15
        clr_i = 1'b1; tick(1); clr_i = 1'b0;
        dir_i = 1'b0; sat_i = 1'b0;
        handshake(2'b11);
        check("down_wrap_cnt", dout_o, 8'hFF);
        check("down_wrap_ovf", ovf_o, 2'b11);
        dir_i = 1'b1; sat_i = 1'b1;
        handshake(2'b01);
        check("sat_up_cnt", dout_o, 8'hFF);

        // Async reset mid-handshake with request held high
        clr_i = 1'b1; tick(1); clr_i = 1'b0;
        req_i = 2'b01;
        tick(3);
        check("pre_rst_ack", ack_o[0], 1'b1);
        check("pre_rst_cnt", dout_o[3:0], 4'd1);
        arst_i = 1'b1;
        #1;
        check("rst_ack_now", ack_o[0], 1'b0);
        check("rst_cnt_now", dout_o[3:0], 4'd0);
        tick(2);
        arst_i = 1'b0;
        tick(2);
        check("post_rst_ack_low", ack_o[0], 1'b0);
        tick(1);
        check("post_rst_ack", ack_o[0], 1'b1);
        check("post_rst_cnt", dout_o[3:0], 4'd1);
        req_i = 2'b00;
        tick(3);
        check("post_rst_hold", dout_o[3:0], 4'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
